// File: rtl/router_port_arbiter_if.sv
// Write-side bundle between NREQ router input ports and one output-port FIFO.
// Requesters and the FIFO sit on the master side; the arbiter is the slave.
interface router_port_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int FLIT_W = 8
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        flit_tail;
    logic [NREQ*FLIT_W-1:0] flit_data;
    logic                   wfull;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        accept;
    logic                   winc;
    logic [FLIT_W-1:0]      wdata;

    modport master (
        output req, flit_tail, flit_data, wfull,
        input  gnt, accept, winc, wdata
    );

    modport slave (
        input  req, flit_tail, flit_data, wfull,
        output gnt, accept, winc, wdata
    );
endinterface

// File: rtl/router_port_arbiter.sv
// Round-robin wormhole arbiter: locks the FIFO write side to one port for a
// whole packet, with a watchdog that force-releases a stalled owner.
//
// state | meaning
// IDLE  | no owner; pick next requester circularly from rr_ptr
// LOCK  | owner_q holds the FIFO until its tail flit or a watchdog timeout
module router_port_arbiter #(
    parameter int  NREQ    = 4,
    parameter int  FLIT_W  = 8,
    parameter int  TIMEOUT = 16,
    localparam int IW      = $clog2(NREQ),
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    router_port_arbiter_if.slave  bus,
    output logic                  busy,
    output logic [IW-1:0]         owner_id,
    output logic                  timeout_err
);
    typedef enum logic {IDLE, LOCK} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     idle_cnt_q, idle_cnt_d;
    logic              timeout_err_q, timeout_err_d;

    logic              found;
    logic [IW-1:0]     pick;
    logic [IW:0]       cand;
    logic [IW-1:0]     next_ptr;
    logic              xfer;

    // Circular search starting at rr_ptr; cand carries one extra bit so the
    // wrap works for any NREQ, not only powers of two.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!found && bus.req[cand[IW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IW-1:0];
            end
        end
    end

    assign next_ptr = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign xfer     = (state_q == LOCK) & bus.req[owner_q] & ~bus.wfull;

    assign bus.gnt     = gnt_q;
    assign bus.winc    = xfer;
    assign bus.accept  = gnt_q & {NREQ{xfer}};
    assign bus.wdata   = bus.flit_data[owner_q*FLIT_W +: FLIT_W];
    assign busy        = (state_q == LOCK);
    assign owner_id    = owner_q;
    assign timeout_err = timeout_err_q;

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        idle_cnt_d    = idle_cnt_q;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = LOCK;
                    gnt_d      = {{(NREQ-1){1'b0}}, 1'b1} << pick;
                    owner_d    = pick;
                    idle_cnt_d = '0;
                end
            end
            LOCK: begin
                if (xfer) begin
                    idle_cnt_d = '0;
                    if (bus.flit_tail[owner_q]) begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        rr_ptr_d = next_ptr;
                    end
                end else if (bus.req[owner_q]) begin
                    // Backpressure from wfull is legitimate; it never ages the watchdog.
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d       = IDLE;
                    gnt_d         = '0;
                    rr_ptr_d      = next_ptr;
                    idle_cnt_d    = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            idle_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            idle_cnt_q    <= idle_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
endmodule

// File: tb/tb_router_port_arbiter.sv
// Bench for router_port_arbiter: directed scenarios followed by random
// requester traffic, all checked against a behavioural model every cycle.
module tb_router_port_arbiter;
    localparam int NREQ    = 4;
    localparam int FLIT_W  = 8;
    localparam int TIMEOUT = 8;
    localparam int IW      = $clog2(NREQ);

    logic          clk = 1'b0;
    logic          rst;
    logic          busy;
    logic [IW-1:0] owner_id;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    // Reference model: lock flag, owner, next search start, idle run length.
    bit m_locked;
    int m_owner;
    int m_rr;
    int m_idle;
    bit m_terr;
    bit m_xfer;
    int m_xport;
    int n_winc;
    int grant_log[$];
    bit pres[NREQ];

    router_port_arbiter_if #(.NREQ(NREQ), .FLIT_W(FLIT_W)) bus ();

    router_port_arbiter #(.NREQ(NREQ), .FLIT_W(FLIT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .owner_id    (owner_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FLIT_W-1:0] port_data(input int i);
        return bus.flit_data[i*FLIT_W +: FLIT_W];
    endfunction

    task automatic set_port(input int i, input bit r, input bit t, input logic [FLIT_W-1:0] d);
        bus.req[i]       = r;
        bus.flit_tail[i] = t;
        bus.flit_data[i*FLIT_W +: FLIT_W] = d;
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_rr     = 0;
        m_idle   = 0;
        m_terr   = 1'b0;
        m_xfer   = 1'b0;
        m_xport  = 0;
        grant_log.delete();
        for (int i = 0; i < NREQ; i++) pres[i] = 1'b0;
    endtask

    task automatic model_edge();
        bit got;
        m_xfer  = m_locked && bus.req[m_owner] && !bus.wfull;
        m_xport = m_owner;
        m_terr  = 1'b0;
        if (!m_locked) begin
            got = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                if (!got && bus.req[(m_rr + k) % NREQ]) begin
                    got     = 1'b1;
                    m_owner = (m_rr + k) % NREQ;
                end
            end
            if (got) begin
                m_locked = 1'b1;
                m_idle   = 0;
                grant_log.push_back(m_owner);
            end
        end else if (m_xfer) begin
            n_winc++;
            m_idle = 0;
            if (bus.flit_tail[m_owner]) begin
                m_locked = 1'b0;
                m_rr     = (m_owner + 1) % NREQ;
            end
        end else if (bus.req[m_owner]) begin
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_locked = 1'b0;
                m_rr     = (m_owner + 1) % NREQ;
                m_terr   = 1'b1;
                m_idle   = 0;
            end
        end
    endtask

    // One clock: compare all outputs at the falling edge, advance the model at
    // the rising edge, return 1 time unit later so callers can drive inputs.
    task automatic cycle();
        bit ex;
        @(negedge clk);
        ex = m_locked && bus.req[m_owner] && !bus.wfull;
        chk("gnt", 32'(bus.gnt), m_locked ? (32'd1 << m_owner) : 32'd0);
        chk("busy", 32'(busy), 32'(m_locked));
        chk("owner_id", 32'(owner_id), 32'(m_owner));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("winc", 32'(bus.winc), 32'(ex));
        chk("accept", 32'(bus.accept), ex ? (32'd1 << m_owner) : 32'd0);
        if (m_locked) chk("wdata", 32'(bus.wdata), 32'(port_data(m_owner)));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        bus.req        = '0;
        bus.flit_tail  = '0;
        bus.flit_data  = '0;
        bus.wfull      = 1'b0;
        #2;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner_id), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_winc", 32'(bus.winc), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int w0;
        int exp_seq[5];
        exp_seq = '{0, 1, 2, 3, 0};
        n_winc  = 0;

        // 3-flit packet on port 0, then rr_ptr must have advanced to 1
        do_reset();
        set_port(0, 1, 0, 8'hA0);
        cycle();
        chk("t1_gnt", 32'(bus.gnt), 32'h1);
        w0 = n_winc;
        cycle();
        set_port(0, 1, 0, 8'hA1);
        cycle();
        set_port(0, 1, 1, 8'hA2);
        cycle();
        set_port(0, 0, 0, 8'h00);
        chk("t1_gnt_off", 32'(bus.gnt), 32'd0);
        chk("t1_busy_off", 32'(busy), 32'd0);
        chk("t1_writes", 32'(n_winc - w0), 32'd3);
        set_port(0, 1, 1, 8'h11);
        set_port(2, 1, 1, 8'h22);
        cycle();
        chk("t1_rr_next", 32'(owner_id), 32'd2);

        // All ports requesting single-flit packets
        do_reset();
        for (int i = 0; i < NREQ; i++) set_port(i, 1, 1, 8'(8'h10 + i));
        w0 = n_winc;
        for (int c = 0; c < 10; c++) cycle();
        chk("t2_ngrants", 32'(grant_log.size()), 32'd5);
        for (int g = 0; g < 5; g++) begin
            if (g < grant_log.size()) chk("t2_grant_seq", 32'(grant_log[g]), 32'(exp_seq[g]));
        end
        chk("t2_writes", 32'(n_winc - w0), 32'd5);

        // Backpressure on a 4-flit packet from port 2
        do_reset();
        set_port(2, 1, 0, 8'hC0);
        cycle();
        w0 = n_winc;
        cycle();
        set_port(2, 1, 0, 8'hC1);
        bus.wfull = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cycle();
            chk("t3_gnt_held", 32'(bus.gnt), 32'h4);
            chk("t3_no_terr", 32'(timeout_err), 32'd0);
        end
        bus.wfull = 1'b0;
        cycle();
        set_port(2, 1, 0, 8'hC2);
        cycle();
        set_port(2, 1, 1, 8'hC3);
        cycle();
        set_port(2, 0, 0, 8'h00);
        chk("t3_writes", 32'(n_winc - w0), 32'd4);
        chk("t3_released", 32'(bus.gnt), 32'd0);

        // Owner 1 stalls after one flit; watchdog fires after TIMEOUT idle cycles
        do_reset();
        set_port(1, 1, 0, 8'hB0);
        cycle();
        cycle();
        set_port(1, 0, 0, 8'hB1);
        for (int c = 0; c < TIMEOUT - 1; c++) cycle();
        chk("t4_still_locked", 32'(bus.gnt), 32'h2);
        chk("t4_no_terr_yet", 32'(timeout_err), 32'd0);
        cycle();
        chk("t4_forced_release", 32'(bus.gnt), 32'd0);
        chk("t4_terr_pulse", 32'(timeout_err), 32'd1);
        for (int i = 0; i < NREQ; i++) set_port(i, 1, 1, 8'(8'h40 + i));
        cycle();
        chk("t4_terr_cleared", 32'(timeout_err), 32'd0);
        chk("t4_next_owner", 32'(owner_id), 32'd2);

        // Asynchronous reset in the middle of port 3's packet
        do_reset();
        set_port(3, 1, 0, 8'hD0);
        cycle();
        cycle();
        set_port(3, 1, 0, 8'hD1);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_gnt_async", 32'(bus.gnt), 32'd0);
        chk("t5_busy_async", 32'(busy), 32'd0);
        chk("t5_winc_async", 32'(bus.winc), 32'd0);
        model_reset();
        bus.req = '0;
        set_port(0, 1, 1, 8'hE0);
        set_port(2, 1, 1, 8'hE2);
        rst = 1'b1;
        cycle();
        chk("t5_gnt_after", 32'(bus.gnt), 32'h1);

        // Waiting ports 0 and 2 are ignored while 1 owns; 2 wins next
        do_reset();
        set_port(1, 1, 0, 8'h50);
        cycle();
        set_port(0, 1, 1, 8'h60);
        set_port(2, 1, 1, 8'h62);
        cycle();
        set_port(1, 1, 0, 8'h51);
        cycle();
        set_port(1, 1, 1, 8'h52);
        cycle();
        set_port(1, 0, 0, 8'h00);
        cycle();
        chk("t6_owner_2", 32'(owner_id), 32'd2);
        cycle();
        set_port(2, 0, 0, 8'h00);
        cycle();
        chk("t6_owner_0", 32'(owner_id), 32'd0);

        // Random traffic: requesters hold each flit until accepted
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_xfer && m_xport == i) pres[i] = 1'b0;
                if (!pres[i] && $urandom_range(0, 1) == 1) begin
                    pres[i] = 1'b1;
                    set_port(i, 1, $urandom_range(0, 2) == 0, 8'($urandom));
                end else if (!pres[i]) begin
                    bus.req[i] = 1'b0;
                end
            end
            bus.wfull = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
